// File: rtl/downmix_decim.sv
// Receive-side mixer: multiplies each input sample by a Q6.14 LO value, saturates the
// product and averages DECIM valid products with an accumulate-and-dump filter.
module downmix_decim #(
  parameter int WIDTH      = 20,
  parameter int FRAC       = 14,
  parameter int DECIM      = 16,
  parameter int LOG2_DECIM = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] rf_i,
  input  logic signed [WIDTH-1:0] LO,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] bb_o,
  output logic                    sat_o
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = WIDTH + LOG2_DECIM;

  localparam logic signed [PW-1:0]    P_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    P_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] M_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] M_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LOG2_DECIM-1:0]   CNT_LAST = LOG2_DECIM'(DECIM - 1);

  logic signed [PW-1:0]    w_mul;
  logic signed [PW-1:0]    r_p;
  logic                    r_v1;
  logic signed [WIDTH-1:0] w_m;
  logic                    w_sat;
  logic signed [AW-1:0]    r_acc;
  logic signed [AW-1:0]    w_sum;
  logic signed [AW-1:0]    w_mean;
  logic [LOG2_DECIM-1:0]   r_cnt;
  logic                    r_sat_acc;

  assign w_mul = rf_i * LO;

  // Stage 1: product register, floor shift by FRAC
  always_ff @(posedge clock) begin
    if (reset) begin
      r_p  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) r_p <= w_mul >>> FRAC;
    end
  end

  always_comb begin
    w_m   = r_p[WIDTH-1:0];
    w_sat = 1'b0;
    if (r_p > P_MAX) begin
      w_m   = M_MAX;
      w_sat = 1'b1;
    end else if (r_p < P_MIN) begin
      w_m   = M_MIN;
      w_sat = 1'b1;
    end
  end

  // Mean of DECIM clamped samples always fits WIDTH, so the dump is a plain truncation
  assign w_sum  = r_acc + {{LOG2_DECIM{w_m[WIDTH-1]}}, w_m};
  assign w_mean = w_sum >>> LOG2_DECIM;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat_acc <= 1'b0;
      out_valid <= 1'b0;
      bb_o      <= '0;
      sat_o     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (r_v1) begin
        if (r_cnt == CNT_LAST) begin
          bb_o      <= w_mean[WIDTH-1:0];
          sat_o     <= r_sat_acc | w_sat;
          out_valid <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sat_acc <= 1'b0;
        end else begin
          r_acc     <= w_sum;
          r_cnt     <= r_cnt + 1'b1;
          r_sat_acc <= r_sat_acc | w_sat;
        end
      end
    end
  end
endmodule

// File: tb/tb_downmix_decim.sv
// Scoreboard bench for downmix_decim: directed blocks push expected (bb, sat, cycle)
// entries; a negedge monitor pops and compares them on every out_valid pulse.
module tb_downmix_decim;
  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [19:0] rf_i = '0;
  logic signed [19:0] LO = '0;
  logic               out_valid;
  logic signed [19:0] bb_o;
  logic               sat_o;

  downmix_decim #(.WIDTH(20), .FRAC(14), .DECIM(16), .LOG2_DECIM(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .rf_i(rf_i), .LO(LO),
    .out_valid(out_valid), .bb_o(bb_o), .sat_o(sat_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [19:0] bb;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          last_cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  bit          hold_en = 1'b0;
  logic [19:0] held = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send(input logic [19:0] rf, input logic [19:0] lo, input int idle = 0);
    rf_i = rf; LO = lo; in_valid = 1'b1;
    @(posedge clock); #1;
    last_cyc = cyc;
    in_valid = 1'b0;
    repeat (idle) begin @(posedge clock); #1; end
  endtask

  // Output due on the cycle after the edge following the block's last sample
  task automatic push(input logic [19:0] bb, input logic sat);
    q.push_back('{bb: bb, sat: sat, cyc: last_cyc + 1});
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_pulse", 20'd1, 20'd0);
      else begin
        e = q.pop_front();
        chk("bb_o", bb_o, e.bb);
        chk("sat_o", {19'd0, sat_o}, {19'd0, e.sat});
        chk("pulse_cycle", 20'(cyc), 20'(e.cyc));
      end
      held = bb_o;
    end else if (hold_en) chk("bb_hold", bb_o, held);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic signed [19:0] ra, rb;
    longint p, s;
    bit st;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", {19'd0, out_valid}, 20'd0);
    chk("rst_bb", bb_o, 20'd0);
    chk("rst_sat", {19'd0, sat_o}, 20'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) send(20'h04000, 20'h04000);
    push(20'h04000, 1'b0);

    for (int i = 0; i < 16; i++) send(20'd100, 20'd300);
    push(20'h00001, 1'b0);
    for (int i = 0; i < 16; i++) send(20'(-100), 20'd300);
    push(20'hFFFFE, 1'b0);

    for (int i = 0; i < 16; i++) send(20'hFC000, 20'h04000);
    push(20'hFC000, 1'b0);
    for (int i = 0; i < 16; i++) send(20'h04000, (i % 2) ? 20'hFC000 : 20'h04000);
    push(20'h00000, 1'b0);

    send(20'h7FFFF, 20'h7FFFF);
    for (int i = 0; i < 15; i++) send(20'h0, 20'h0);
    push(20'h07FFF, 1'b1);
    for (int i = 0; i < 16; i++) send(20'h0, 20'h0);
    push(20'h00000, 1'b0);

    @(negedge clock);
    hold_en = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) send(20'h04000, 20'h04000, $urandom_range(0, 5));
    push(20'h04000, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    for (int i = 0; i < 64; i++) begin
      send(20'h04000, 20'h04000);
      if (i % 16 == 15) push(20'h04000, 1'b0);
    end
    repeat (4) begin @(posedge clock); #1; end
    hold_en = 1'b0;

    // Random operands checked against a long-integer reference of the arithmetic
    for (int b = 0; b < 3; b++) begin
      s = 0; st = 1'b0;
      for (int i = 0; i < 16; i++) begin
        ra = 20'($urandom);
        rb = (b == 0) ? 20'($urandom_range(0, 32767)) : 20'($urandom);
        p = (longint'(ra) * longint'(rb)) >>> 14;
        if (p > 524287) begin p = 524287; st = 1'b1; end
        else if (p < -524288) begin p = -524288; st = 1'b1; end
        s += p;
        send(ra, rb);
      end
      push(20'(s >>> 4), st);
    end
    repeat (3) begin @(posedge clock); #1; end

    for (int i = 0; i < 10; i++) send(20'h7FFFF, 20'h04000);
    reset = 1'b1; in_valid = 1'b1; rf_i = 20'h7FFFF; LO = 20'h7FFFF;
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", {19'd0, out_valid}, 20'd0);
    chk("midrst_bb", bb_o, 20'd0);
    chk("midrst_sat", {19'd0, sat_o}, 20'd0);
    @(posedge clock); #1;
    chk("postrst_out_valid", {19'd0, out_valid}, 20'd0);
    for (int i = 0; i < 16; i++) send(20'h02000, 20'h04000);
    push(20'h02000, 1'b0);

    repeat (5) begin @(posedge clock); #1; end
    chk("pending_expect", 20'(q.size()), 20'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
